alu_result_buffer: RTL and testbench

- Downstream stage of the 8-bit ALU: captures each ALU result with its opcode and operands, derives status flags, and buffers the entries in a small FIFO for the writeback/consumer stage.
- Uses valid/ready handshakes on both sides, so a stalling consumer back-pressures the ALU issue logic.
- Also keeps saturating event counters for debug.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/alu_result_buffer.sv | 104 ++++++++++
 tb/tb_alu_result_buffer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: opcodes, flag bit positions and the buffered entry.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_OR  = 4'b0011,
    OP_XOR = 4'b0100,
    OP_NOT = 4'b0101,
    OP_INC = 4'b0110,
    OP_NEG = 4'b0111,
    OP_SHL = 4'b1000,
    OP_SHR = 4'b1001,
    OP_ROL = 4'b1010,
    OP_ROR = 4'b1011,
    OP_MUL = 4'b1100,
    OP_DIV = 4'b1101,
    OP_MOD = 4'b1110,
    OP_NOP = 4'b1111
  } alu_op_e;

  localparam int FLAG_W = 5;
  localparam int FLG_Z  = 0;
  localparam int FLG_C  = 1;
  localparam int FLG_N  = 2;
  localparam int FLG_V  = 3;
  localparam int FLG_DZ = 4;

  typedef struct packed {
    logic [3:0]        op;
    logic [15:0]       result;
    logic [FLAG_W-1:0] flags;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous flush; 1-cycle push-to-head latency.
// Head data reads zero when empty; pushes when full and pops when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_dat,
  output logic [WIDTH-1:0]         o_dat,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

  // Flush wins over both sides so a flushing cycle never moves data.
  assign w_push = i_push && !o_full  && !i_flush;
  assign w_pop  = i_pop  && !o_empty && !i_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_dat;
    end
  end

  assign o_dat = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/alu_result_buffer.sv
// Captures ALU results with derived {DZ,V,N,C,Z} flags into a FIFO for writeback; 1-cycle latency.
// in_ready drops while full (not pop-aware); saturating debug counters survive flush.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_op,
  input  logic [7:0]             in_a,
  input  logic [7:0]             in_b,
  input  logic [15:0]            in_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_op,
  output logic [15:0]            out_result,
  output logic [FLAG_W-1:0]      out_flags,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       res_cnt,
  output logic [CNT_W-1:0]       dz_cnt
);

  logic [FLAG_W-1:0] w_flags;
  entry_t            w_in_entry;
  entry_t            w_head;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_accept;
  logic [CNT_W-1:0]  r_res_cnt;
  logic [CNT_W-1:0]  r_dz_cnt;

  always_comb begin
    w_flags = '0;
    w_flags[FLG_Z] = (in_result == 16'h0000);

    case (in_op)
      OP_ADD, OP_INC, OP_SHL: w_flags[FLG_C] = in_result[8];
      OP_SUB:                 w_flags[FLG_C] = (in_a < in_b);
      OP_NEG:                 w_flags[FLG_C] = (in_a == 8'h00);
      OP_SHR:                 w_flags[FLG_C] = in_a[0];
      default:                w_flags[FLG_C] = 1'b0;
    endcase

    w_flags[FLG_N] = (in_op == OP_MUL) ? in_result[15] : in_result[7];

    // Signed 8-bit overflow only meaningful for add/subtract.
    case (in_op)
      OP_ADD:  w_flags[FLG_V] = (in_a[7] == in_b[7]) && (in_result[7] != in_a[7]);
      OP_SUB:  w_flags[FLG_V] = (in_a[7] != in_b[7]) && (in_result[7] != in_a[7]);
      default: w_flags[FLG_V] = 1'b0;
    endcase

    w_flags[FLG_DZ] = (in_op == OP_DIV) && (in_b == 8'h00);
  end

  assign w_in_entry = '{op: in_op, result: in_result, flags: w_flags};

  assign in_ready = !rst && !w_full;
  assign w_push   = in_valid && in_ready;
  assign w_accept = w_push && !flush;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .i_push  (w_push),
    .i_pop   (out_ready),
    .i_dat   (w_in_entry),
    .o_dat   (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (level)
  );

  assign out_valid  = !w_empty;
  assign out_op     = w_head.op;
  assign out_result = w_head.result;
  assign out_flags  = w_head.flags;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_cnt <= '0;
      r_dz_cnt  <= '0;
    end else begin
      if (w_accept && (r_res_cnt != '1))
        r_res_cnt <= r_res_cnt + CNT_W'(1);
      if (w_accept && w_flags[FLG_DZ] && (r_dz_cnt != '1))
        r_dz_cnt <= r_dz_cnt + CNT_W'(1);
    end
  end

  assign res_cnt = r_res_cnt;
  assign dz_cnt  = r_dz_cnt;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Scoreboard bench for alu_result_buffer: directed plan steps plus randomized traffic vs a queue model.
module tb_alu_result_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [15:0] in_result;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [15:0] out_result;
  logic [4:0]  out_flags;
  logic [2:0]  level;
  logic [7:0]  res_cnt;
  logic [7:0]  dz_cnt;

  alu_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .in_result(in_result), .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_result(out_result), .out_flags(out_flags), .level(level),
    .res_cnt(res_cnt), .dz_cnt(dz_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] res;
    logic [4:0]  flg;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   m_res  = 0;
  int   m_dz   = 0;
  bit   p_push = 0;
  bit   p_flush = 0;
  exp_t p_item;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Flags as the consumer expects them, straight from the opcode rules.
  function automatic logic [4:0] exp_flags(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic [15:0] r);
    logic z, c, n, v, dz;
    z = (r == 0);
    if (op == 4'd0 || op == 4'd6 || op == 4'd8) c = r[8];
    else if (op == 4'd1) c = (a < b);
    else if (op == 4'd7) c = (a == 0);
    else if (op == 4'd9) c = a[0];
    else c = 0;
    n = (op == 4'd12) ? r[15] : r[7];
    if (op == 4'd0)      v = (a[7] == b[7]) && (r[7] != a[7]);
    else if (op == 4'd1) v = (a[7] != b[7]) && (r[7] != a[7]);
    else v = 0;
    dz = (op == 4'd13) && (b == 0);
    return {dz, v, n, c, z};
  endfunction

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  // Observe the handshake mid-cycle, commit it to the model at the edge.
  always @(negedge clk) begin
    p_flush = flush;
    p_push  = !rst && in_valid && in_ready && !flush;
    p_item  = '{op: in_op, res: in_result, flg: exp_flags(in_op, in_a, in_b, in_result)};
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (p_flush) q.delete();
      else if (p_push) begin
        q.push_back(p_item);
        m_res++;
        if (p_item.flg[4]) m_dz++;
      end
    end
  end

  // Monitor: compares DUT head and status against the model every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("level", level, q.size());
      check("out_valid", out_valid, q.size() != 0);
      check("res_cnt", res_cnt, sat(m_res));
      check("dz_cnt", dz_cnt, sat(m_dz));
      if (!out_valid) begin
        check("empty_head", {out_op, out_result, out_flags}, 0);
      end else if (out_ready && !flush) begin
        check("model_has_entry", q.size() != 0, 1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          check("out_op", out_op, e.op);
          check("out_result", out_result, e.res);
          check("out_flags", out_flags, e.flg);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] r);
    bit done;
    done = 0;
    in_valid = 1; in_op = op; in_a = a; in_b = b; in_result = r;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready && !flush) done = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    check("send_accepted", done, 1);
  endtask

  task automatic drain();
    out_ready = 1;
    for (int i = 0; i < 50 && (q.size() != 0 || out_valid); i++) cyc(1);
    check("drain_empty", q.size(), 0);
  endtask

  task automatic model_reset();
    q.delete();
    m_res = 0;
    m_dz  = 0;
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 0;
    in_op = 0; in_a = 0; in_b = 0; in_result = 0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_head", {out_op, out_result, out_flags}, 0);
    check("rst_cnts", {res_cnt, dz_cnt}, 0);
    cyc(2);
    rst = 0;
    #1;
    check("in_ready_after_rst", in_ready, 1);
    cyc(1);

    // Flag derivation cases
    out_ready = 1;
    send(4'b0000, 8'hFF, 8'h01, 16'h0100);
    check("t1_valid", out_valid, 1);
    check("t1_result", out_result, 16'h0100);
    check("t1_flags", out_flags, 5'b00010);
    check("t1_res_cnt", res_cnt, 1);
    send(4'b0001, 8'h7F, 8'h80, 16'hFFFF);
    check("t2a_flags", out_flags, 5'b01110);
    send(4'b0001, 8'h05, 8'h05, 16'h0000);
    check("t2b_flags", out_flags, 5'b00001);
    send(4'b1101, 8'h10, 8'h00, 16'h0000);
    check("t3a_flags", out_flags, 5'b10001);
    check("t3a_dz_cnt", dz_cnt, 1);
    send(4'b1101, 8'h10, 8'h04, 16'h0004);
    check("t3b_flags", out_flags, 5'b00000);
    drain();

    // Fill to full; fifth offer must be refused
    out_ready = 0;
    cyc(1);
    for (int i = 1; i <= 4; i++) send(4'b0010, 8'h00, 8'h00, 16'(i));
    check("full_in_ready", in_ready, 0);
    check("full_level", level, 4);
    in_valid = 1; in_result = 16'd5;
    cyc(3);
    check("full_hold_level", level, 4);
    in_valid = 0;
    drain();
    check("after_drain_level", level, 0);

    // Simultaneous push/pop at level 2 and at full
    out_ready = 0;
    cyc(1);
    send(4'b0011, 8'h01, 8'h02, 16'h0011);
    send(4'b0011, 8'h01, 8'h02, 16'h0012);
    in_valid = 1; in_result = 16'h0013; out_ready = 1;
    cyc(1);
    in_valid = 0; out_ready = 0;
    check("pushpop_level", level, 2);
    drain();
    out_ready = 0;
    cyc(1);
    for (int i = 0; i < 4; i++) send(4'b0100, 8'h00, 8'h00, 16'h0020 + 16'(i));
    in_valid = 1; in_result = 16'h0099; out_ready = 1;
    cyc(1);
    in_valid = 0; out_ready = 0;
    check("full_pop_level", level, 3);
    drain();

    // Random traffic, long enough to saturate res_cnt
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_op     = 4'($urandom_range(0, 15));
      in_a      = 8'($urandom);
      in_b      = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      case ($urandom_range(0, 3))
        0:       in_result = 16'h0000;
        1:       in_result = 16'(in_a) + 16'(in_b);
        2:       in_result = 16'(in_a) - 16'(in_b);
        default: in_result = 16'($urandom);
      endcase
      flush     = ($urandom_range(0, 49) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc(1);
    end
    flush = 0; in_valid = 0;
    drain();
    check("res_cnt_saturated", res_cnt, sat(m_res));

    // Flush with a concurrent offer, after a fresh reset
    rst = 1;
    model_reset();
    cyc(1);
    rst = 0;
    #1;
    check("in_ready_after_rst2", in_ready, 1);
    cyc(1);
    out_ready = 0;
    for (int i = 0; i < 3; i++) send(4'b0000, 8'h01, 8'h01, 16'h0002);
    in_valid = 1; flush = 1;
    cyc(1);
    in_valid = 0; flush = 0;
    check("flush_level", level, 0);
    check("flush_out_valid", out_valid, 0);
    check("flush_res_cnt", res_cnt, 3);

    // Asynchronous reset between edges
    send(4'b1101, 8'h01, 8'h00, 16'h0000);
    send(4'b0000, 8'h01, 8'h01, 16'h0002);
    @(negedge clk);
    #2;
    rst = 1;
    model_reset();
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_level", level, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_head", {out_op, out_result, out_flags}, 0);
    check("arst_res_cnt", res_cnt, 0);
    check("arst_dz_cnt", dz_cnt, 0);
    @(posedge clk);
    #1;
    rst = 0;
    cyc(2);
    check("post_arst_level", level, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
